// File: rtl/axis_bus_mux_arb.sv
// axis_bus_mux_arb: merges 12 AXI-Stream channels into one master stream.
// A channel is picked round-robin and held until its tlast beat is accepted.
// The grant is published on bus_sel as 128+n (0 when no channel is held).
// Optional feature macro: AXIS_MUX_PKT_CNT_EN enables the packet counter on
// pkt_cnt; without it pkt_cnt is tied to zero.
module axis_bus_mux_arb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] axis_in_0_tdata,
    input  logic                  axis_in_0_tvalid,
    input  logic                  axis_in_0_tlast,
    output logic                  axis_in_0_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_1_tdata,
    input  logic                  axis_in_1_tvalid,
    input  logic                  axis_in_1_tlast,
    output logic                  axis_in_1_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_2_tdata,
    input  logic                  axis_in_2_tvalid,
    input  logic                  axis_in_2_tlast,
    output logic                  axis_in_2_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_3_tdata,
    input  logic                  axis_in_3_tvalid,
    input  logic                  axis_in_3_tlast,
    output logic                  axis_in_3_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_4_tdata,
    input  logic                  axis_in_4_tvalid,
    input  logic                  axis_in_4_tlast,
    output logic                  axis_in_4_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_5_tdata,
    input  logic                  axis_in_5_tvalid,
    input  logic                  axis_in_5_tlast,
    output logic                  axis_in_5_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_6_tdata,
    input  logic                  axis_in_6_tvalid,
    input  logic                  axis_in_6_tlast,
    output logic                  axis_in_6_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_7_tdata,
    input  logic                  axis_in_7_tvalid,
    input  logic                  axis_in_7_tlast,
    output logic                  axis_in_7_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_8_tdata,
    input  logic                  axis_in_8_tvalid,
    input  logic                  axis_in_8_tlast,
    output logic                  axis_in_8_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_9_tdata,
    input  logic                  axis_in_9_tvalid,
    input  logic                  axis_in_9_tlast,
    output logic                  axis_in_9_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_10_tdata,
    input  logic                  axis_in_10_tvalid,
    input  logic                  axis_in_10_tlast,
    output logic                  axis_in_10_tready,
    input  logic [DATA_WIDTH-1:0] axis_in_11_tdata,
    input  logic                  axis_in_11_tvalid,
    input  logic                  axis_in_11_tlast,
    output logic                  axis_in_11_tready,
    output logic [DATA_WIDTH-1:0] axis_out_tdata,
    output logic                  axis_out_tvalid,
    output logic                  axis_out_tlast,
    input  logic                  axis_out_tready,
    output logic [7:0]            bus_sel,
    output logic [15:0]           pkt_cnt
);

    localparam int NCH = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            grant_q, grant_d;
    logic [3:0]            last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
    logic                  out_tvalid_q, out_tvalid_d;
    logic                  out_tlast_q, out_tlast_d;

    logic [DATA_WIDTH-1:0] in_tdata [NCH];
    logic [NCH-1:0]        in_tvalid;
    logic [NCH-1:0]        in_tlast;
    logic [NCH-1:0]        in_tready;

    logic                  slice_free;
    logic                  accept;
    logic                  found;
    logic [4:0]            idx;

    // Gather the flat channel ports into indexable vectors.
    assign in_tdata[0]  = axis_in_0_tdata;
    assign in_tdata[1]  = axis_in_1_tdata;
    assign in_tdata[2]  = axis_in_2_tdata;
    assign in_tdata[3]  = axis_in_3_tdata;
    assign in_tdata[4]  = axis_in_4_tdata;
    assign in_tdata[5]  = axis_in_5_tdata;
    assign in_tdata[6]  = axis_in_6_tdata;
    assign in_tdata[7]  = axis_in_7_tdata;
    assign in_tdata[8]  = axis_in_8_tdata;
    assign in_tdata[9]  = axis_in_9_tdata;
    assign in_tdata[10] = axis_in_10_tdata;
    assign in_tdata[11] = axis_in_11_tdata;

    assign in_tvalid = {axis_in_11_tvalid, axis_in_10_tvalid, axis_in_9_tvalid,
                        axis_in_8_tvalid,  axis_in_7_tvalid,  axis_in_6_tvalid,
                        axis_in_5_tvalid,  axis_in_4_tvalid,  axis_in_3_tvalid,
                        axis_in_2_tvalid,  axis_in_1_tvalid,  axis_in_0_tvalid};

    assign in_tlast  = {axis_in_11_tlast, axis_in_10_tlast, axis_in_9_tlast,
                        axis_in_8_tlast,  axis_in_7_tlast,  axis_in_6_tlast,
                        axis_in_5_tlast,  axis_in_4_tlast,  axis_in_3_tlast,
                        axis_in_2_tlast,  axis_in_1_tlast,  axis_in_0_tlast};

    assign axis_in_0_tready  = in_tready[0];
    assign axis_in_1_tready  = in_tready[1];
    assign axis_in_2_tready  = in_tready[2];
    assign axis_in_3_tready  = in_tready[3];
    assign axis_in_4_tready  = in_tready[4];
    assign axis_in_5_tready  = in_tready[5];
    assign axis_in_6_tready  = in_tready[6];
    assign axis_in_7_tready  = in_tready[7];
    assign axis_in_8_tready  = in_tready[8];
    assign axis_in_9_tready  = in_tready[9];
    assign axis_in_10_tready = in_tready[10];
    assign axis_in_11_tready = in_tready[11];

    assign axis_out_tdata  = out_tdata_q;
    assign axis_out_tvalid = out_tvalid_q;
    assign axis_out_tlast  = out_tlast_q;
    assign bus_sel         = (state_q == GRANT) ? {4'b1000, grant_q} : 8'd0;

    // Arbitration, grant lock, input handshake and output slice update.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        out_tdata_d  = out_tdata_q;
        out_tvalid_d = out_tvalid_q;
        out_tlast_d  = out_tlast_q;
        in_tready    = '0;
        accept       = 1'b0;
        found        = 1'b0;
        idx          = 5'd0;
        // The slice can take a beat when empty or when it drains this cycle.
        slice_free   = !out_tvalid_q || axis_out_tready;

        // The slice drains in either state; a fresh accept below overrides.
        if (out_tvalid_q && axis_out_tready) begin
            out_tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Scan last_grant+1 upward, wrapping, so last_grant is lowest.
                for (int i = 1; i <= NCH; i++) begin
                    idx = {1'b0, last_grant_q} + 5'(i);
                    if (idx >= 5'(NCH)) begin
                        idx = idx - 5'(NCH);
                    end
                    if (!found && in_tvalid[idx[3:0]]) begin
                        found   = 1'b1;
                        grant_d = idx[3:0];
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                in_tready[grant_q] = slice_free;
                accept = in_tvalid[grant_q] && slice_free;
                if (accept) begin
                    out_tdata_d  = in_tdata[grant_q];
                    out_tlast_d  = in_tlast[grant_q];
                    out_tvalid_d = 1'b1;
                    if (in_tlast[grant_q]) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and output slice registers; reset aborts any packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 4'd0;
            last_grant_q <= 4'd11;
            out_tdata_q  <= '0;
            out_tvalid_q <= 1'b0;
            out_tlast_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_tdata_q  <= out_tdata_d;
            out_tvalid_q <= out_tvalid_d;
            out_tlast_q  <= out_tlast_d;
        end
    end

`ifdef AXIS_MUX_PKT_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    // Count accepted end-of-packet beats, wrapping at 16 bits.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (accept && in_tlast[grant_q]) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    // Packet counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q <= 16'd0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`else
    assign pkt_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_axis_bus_mux_arb.sv
// Bench for axis_bus_mux_arb: per-channel source queues, a packet-level
// reference model checked every cycle, and directed scenarios with literal
// expectations.
module tb_axis_bus_mux_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_d [12];
    logic [11:0] in_v;
    logic [11:0] in_l;
    wire  [11:0] in_r;
    wire  [31:0] out_d;
    wire         out_v;
    wire         out_l;
    logic        out_rdy;
    wire  [7:0]  bus_sel;
    wire  [15:0] pkt_cnt;

    always #5 clk = ~clk;

    axis_bus_mux_arb #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .axis_in_0_tdata(in_d[0]),   .axis_in_0_tvalid(in_v[0]),   .axis_in_0_tlast(in_l[0]),   .axis_in_0_tready(in_r[0]),
        .axis_in_1_tdata(in_d[1]),   .axis_in_1_tvalid(in_v[1]),   .axis_in_1_tlast(in_l[1]),   .axis_in_1_tready(in_r[1]),
        .axis_in_2_tdata(in_d[2]),   .axis_in_2_tvalid(in_v[2]),   .axis_in_2_tlast(in_l[2]),   .axis_in_2_tready(in_r[2]),
        .axis_in_3_tdata(in_d[3]),   .axis_in_3_tvalid(in_v[3]),   .axis_in_3_tlast(in_l[3]),   .axis_in_3_tready(in_r[3]),
        .axis_in_4_tdata(in_d[4]),   .axis_in_4_tvalid(in_v[4]),   .axis_in_4_tlast(in_l[4]),   .axis_in_4_tready(in_r[4]),
        .axis_in_5_tdata(in_d[5]),   .axis_in_5_tvalid(in_v[5]),   .axis_in_5_tlast(in_l[5]),   .axis_in_5_tready(in_r[5]),
        .axis_in_6_tdata(in_d[6]),   .axis_in_6_tvalid(in_v[6]),   .axis_in_6_tlast(in_l[6]),   .axis_in_6_tready(in_r[6]),
        .axis_in_7_tdata(in_d[7]),   .axis_in_7_tvalid(in_v[7]),   .axis_in_7_tlast(in_l[7]),   .axis_in_7_tready(in_r[7]),
        .axis_in_8_tdata(in_d[8]),   .axis_in_8_tvalid(in_v[8]),   .axis_in_8_tlast(in_l[8]),   .axis_in_8_tready(in_r[8]),
        .axis_in_9_tdata(in_d[9]),   .axis_in_9_tvalid(in_v[9]),   .axis_in_9_tlast(in_l[9]),   .axis_in_9_tready(in_r[9]),
        .axis_in_10_tdata(in_d[10]), .axis_in_10_tvalid(in_v[10]), .axis_in_10_tlast(in_l[10]), .axis_in_10_tready(in_r[10]),
        .axis_in_11_tdata(in_d[11]), .axis_in_11_tvalid(in_v[11]), .axis_in_11_tlast(in_l[11]), .axis_in_11_tready(in_r[11]),
        .axis_out_tdata(out_d), .axis_out_tvalid(out_v), .axis_out_tlast(out_l),
        .axis_out_tready(out_rdy), .bus_sel(bus_sel), .pkt_cnt(pkt_cnt)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    // Source queues: {tlast, tdata} per beat, front beat is what is offered.
    logic [32:0] src_q [12][$];
    logic [11:0] acc;

    // Reference model state.
    int          m_lock = -1;
    int          m_last = 11;
    logic        m_sv = 1'b0;
    logic [31:0] m_sd = '0;
    logic        m_sl = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [15:0] cnt_ofs = '0;

    // Logs written only by the monitor.
    int          glog [$];
    int          gcyc [$];
    logic [32:0] out_log [$];
    logic [7:0]  bsel_log [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, need 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int n = 0; n < 12; n++) begin
            if (src_q[n].size() > 0) begin
                {in_l[n], in_d[n]} = src_q[n][0];
                in_v[n] = 1'b1;
            end else begin
                in_l[n] = 1'b0;
                in_d[n] = '0;
                in_v[n] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int n = 0; n < 12; n++) begin
            if (acc[n] && src_q[n].size() > 0) begin
                void'(src_q[n].pop_front());
            end
        end
        drive();
    endtask

    task automatic drain(input string nm);
        bit   done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            done = 1'b1;
            for (int n = 0; n < 12; n++) begin
                if (src_q[n].size() > 0) done = 1'b0;
            end
            if (out_v || bus_sel != 8'd0) done = 1'b0;
        end
        chk(nm, done, 1'b1);
    endtask

    // Monitor: compare DUT against the model each cycle, then advance the model.
    initial begin
        logic [7:0]  exp_sel;
        logic [11:0] exp_rdy;
        logic [15:0] exp_cnt;
        bit          was_idle;
        int          c;
        acc = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                m_lock = -1; m_last = 11; m_sv = 1'b0; m_sd = '0; m_sl = 1'b0; m_cnt = '0;
                acc = '0;
                chk("rst_bus_sel", bus_sel, 8'd0);
                chk("rst_tready", in_r, 12'd0);
                chk("rst_out_tvalid", out_v, 1'b0);
                chk("rst_out_tdata", out_d, 32'd0);
                chk("rst_pkt_cnt", pkt_cnt, 16'd0);
            end else begin
                exp_sel = (m_lock < 0) ? 8'd0 : 8'(128 + m_lock);
                exp_rdy = '0;
                if (m_lock >= 0 && (!m_sv || out_rdy)) exp_rdy[m_lock] = 1'b1;
`ifdef AXIS_MUX_PKT_CNT_EN
                exp_cnt = m_cnt + cnt_ofs;
`else
                exp_cnt = 16'd0;
`endif
                chk("bus_sel", bus_sel, exp_sel);
                chk("tready", in_r, exp_rdy);
                chk("out_tvalid", out_v, m_sv);
                if (m_sv) begin
                    chk("out_tdata", out_d, m_sd);
                    chk("out_tlast", out_l, m_sl);
                end
                chk("pkt_cnt", pkt_cnt, exp_cnt);
                bsel_log.push_back(bus_sel);
                if (out_v && out_rdy) out_log.push_back({out_l, out_d});
                acc = in_v & in_r;
                // Advance the model across the coming edge.
                was_idle = (m_lock < 0);
                if (!was_idle && in_v[m_lock] && exp_rdy[m_lock]) begin
                    m_sv = 1'b1;
                    m_sd = in_d[m_lock];
                    m_sl = in_l[m_lock];
                    if (m_sl) begin
                        m_cnt++;
                        m_last = m_lock;
                        m_lock = -1;
                    end
                end else if (out_rdy) begin
                    m_sv = 1'b0;
                end
                if (was_idle) begin
                    for (int k = 1; k <= 12 && m_lock < 0; k++) begin
                        c = (m_last + k) % 12;
                        if (in_v[c]) begin
                            m_lock = c;
                            glog.push_back(c);
                            gcyc.push_back(cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios.
    initial begin
        int g0, o0, b0;
        bit hit;
        logic [32:0] exp_beats [4];
        out_rdy = 1'b1;

        // Reset with every channel valid; two single-beat packets per channel.
        for (int n = 0; n < 12; n++) begin
            src_q[n].push_back({1'b1, 32'h100 + 32'(n)});
            src_q[n].push_back({1'b1, 32'h200 + 32'(n)});
        end
        drive();
        repeat (3) step();
        g0 = glog.size();
        rst = 1'b0;
        step();
        chk("t1_bus_sel_ch0", bus_sel, 8'd128);
        chk("t1_only_ch0_ready", in_r, 12'h001);
        step();
        chk("t1_first_beat_valid", out_v, 1'b1);
        chk("t1_first_beat_data", out_d, 32'h100);
        drain("t1_drain");
        for (int k = 0; k < 24; k++) begin
            chk("t1_grant_order", glog[g0 + k], k % 12);
            if (k > 0) chk("t1_two_cycles_per_pkt", gcyc[g0 + k] - gcyc[g0 + k - 1], 2);
        end
        chk("t1_model_pkts", m_cnt, 16'd24);
`ifdef AXIS_MUX_PKT_CNT_EN
        chk("t1_pkt_cnt", pkt_cnt, 16'd24);
`else
        chk("t1_pkt_cnt_off", pkt_cnt, 16'd0);
`endif

        // Two 2-beat packets on channels 3 and 7.
        o0 = out_log.size();
        b0 = bsel_log.size();
        src_q[3].push_back({1'b0, 32'hA0}); src_q[3].push_back({1'b1, 32'hA1});
        src_q[7].push_back({1'b0, 32'hB0}); src_q[7].push_back({1'b1, 32'hB1});
        drive();
        drain("t2_drain");
        exp_beats = '{{1'b0, 32'hA0}, {1'b1, 32'hA1}, {1'b0, 32'hB0}, {1'b1, 32'hB1}};
        chk("t2_beat_count", out_log.size() - o0, 4);
        for (int i = 0; i < 4; i++) chk("t2_beat", out_log[o0 + i], exp_beats[i]);
        chk("t2_sel0", bsel_log[b0],     8'd0);
        chk("t2_sel1", bsel_log[b0 + 1], 8'd131);
        chk("t2_sel2", bsel_log[b0 + 2], 8'd131);
        chk("t2_sel3", bsel_log[b0 + 3], 8'd0);
        chk("t2_sel4", bsel_log[b0 + 4], 8'd135);
        chk("t2_sel5", bsel_log[b0 + 5], 8'd135);

        // Channel 5, 4 beats, downstream stalls for 5 cycles on beat 2.
        o0 = out_log.size();
        for (int i = 0; i < 4; i++) src_q[5].push_back({(i == 3), 32'hC0 + 32'(i)});
        drive();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (out_v && out_d == 32'hC1) hit = 1'b1;
        end
        chk("t3_reach_beat2", hit, 1'b1);
        out_rdy = 1'b0;
        repeat (5) begin
            #1;
            chk("t3_hold_valid", out_v, 1'b1);
            chk("t3_hold_data", out_d, 32'hC1);
            chk("t3_ch5_not_ready", in_r[5], 1'b0);
            step();
        end
        out_rdy = 1'b1;
        drain("t3_drain");
        chk("t3_beat_count", out_log.size() - o0, 4);
        for (int i = 0; i < 4; i++) chk("t3_beat", out_log[o0 + i], {(i == 3), 32'hC0 + 32'(i)});

        // Reset in the middle of a packet on channel 9.
        for (int i = 0; i < 4; i++) src_q[9].push_back({(i == 3), 32'hD0 + 32'(i)});
        drive();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (out_v && bus_sel == 8'd137) hit = 1'b1;
        end
        chk("t4_mid_packet", hit, 1'b1);
        rst = 1'b1;
        #1;
        chk("t4_async_tvalid", out_v, 1'b0);
        chk("t4_async_tdata", out_d, 32'd0);
        chk("t4_async_tlast", out_l, 1'b0);
        chk("t4_async_bus_sel", bus_sel, 8'd0);
        chk("t4_async_tready", in_r, 12'd0);
        chk("t4_async_pkt_cnt", pkt_cnt, 16'd0);
        for (int n = 0; n < 12; n++) src_q[n].delete();
        src_q[0].push_back({1'b1, 32'hE0});
        src_q[11].push_back({1'b1, 32'hF0});
        drive();
        step();
        step();
        rst = 1'b0;
        step();
        chk("t4_ch0_wins", bus_sel, 8'd128);
        drain("t4_drain");

`ifdef AXIS_MUX_PKT_CNT_EN
        // Counter wrap: preload 0xFFFE, then two packets.
        force dut.pkt_cnt_q = 16'hFFFE;
        #1;
        release dut.pkt_cnt_q;
        cnt_ofs = 16'hFFFE - m_cnt;
        src_q[2].push_back({1'b1, 32'h77});
        src_q[2].push_back({1'b1, 32'h78});
        drive();
        drain("t5_drain");
        chk("t5_pkt_cnt_wrap", pkt_cnt, 16'h0000);
`else
        src_q[2].push_back({1'b1, 32'h77});
        src_q[2].push_back({1'b1, 32'h78});
        drive();
        drain("t5_drain");
        chk("t5_pkt_cnt_off", pkt_cnt, 16'h0000);
`endif

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_bus_mux_arb.md
# axis_bus_mux_arb

Packet-level arbiter and multiplexer that merges 12 AXI-Stream FIFO outputs into a single AXI-Stream master. It is the transmit-side counterpart of `axis_bus_demux`. It picks one input channel round-robin and locks it until that channel's `tlast` beat is accepted. It publishes the grant as an 8-bit `bus_sel` code in the same encoding the demux decodes: 128+n for channel n, 0 for none. It sits between the channel FIFOs and the shared downstream stream consumer.

## Interface
Parameters:
- DATA_WIDTH, 32, width of every tdata bus

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- axis_in_n_tdata  in  DATA_WIDTH  channel n data, n = 0..11
- axis_in_n_tvalid  in  1  channel n valid, n = 0..11
- axis_in_n_tlast  in  1  channel n end of packet, n = 0..11
- axis_in_n_tready  out  1  channel n ready, n = 0..11
- axis_out_tdata  out  DATA_WIDTH  merged data, registered
- axis_out_tvalid  out  1  merged valid, registered
- axis_out_tlast  out  1  merged last, registered
- axis_out_tready  in  1  downstream ready
- bus_sel  out  8  current grant: 128+n while channel n is locked, 0 otherwise
- pkt_cnt  out  16  count of packets forwarded; see Configuration

## Operation
- State machine: IDLE, GRANT. Registers: grant[3:0], last_grant[3:0], output slice (tdata, tvalid, tlast).
- IDLE:
  - All axis_in_n_tready are 0 and bus_sel = 0.
  - If any tvalid is high, grant the first valid channel in the order last_grant+1 … 11, 0 … last_grant.
  - Then go to GRANT on the next edge.
- GRANT:
  - bus_sel = 128 + grant.
  - axis_in_n_tready = (n == grant) && (!axis_out_tvalid || axis_out_tready). Every other channel's tready is 0.
  - An input beat is accepted when the granted tvalid and tready are both high. The accepted beat is loaded into the output slice and axis_out_tvalid is set.
  - If axis_out_tready is high and no new beat is accepted in that cycle, axis_out_tvalid clears.
  - While axis_out_tvalid = 1 and axis_out_tready = 0, tdata and tlast are held unchanged.
- Packet end:
  - When the accepted beat has tlast = 1, last_grant <= grant and the next state is IDLE.
  - The output slice may still hold that beat on entry to IDLE; it drains normally while in IDLE.
- A grant is never revoked mid-packet. If the granted tvalid drops mid-packet, the block stays in GRANT and waits.
- Single-beat packets (tvalid and tlast high together) are legal.

## Timing
Reset values, asserted asynchronously:
- state = IDLE, grant = 0, last_grant = 11, so channel 0 has first priority.
- axis_out_tvalid = 0, axis_out_tdata = 0, axis_out_tlast = 0.
- All axis_in_n_tready = 0, bus_sel = 0, pkt_cnt = 0.

Latency and throughput:
- tvalid seen in IDLE → bus_sel valid and tready possible on the next cycle.
- Input beat accepted at edge k → on axis_out starting at cycle k+1.
- Within a packet with no backpressure: one beat per cycle.
- Between packets: exactly one IDLE cycle, so a packet of B beats costs B+1 cycles.
- Backpressure: axis_out_tready low with the slice full drops the granted input's tready combinationally in the same cycle. No beat is lost or duplicated.

Boundary conditions:
- Reset during a packet aborts it. The output slice is cleared and round-robin priority returns to channel 0.
- Simultaneous tlast acceptance and a new tvalid on the same channel: that channel drops to lowest priority for the next arbitration.

## Configuration
- Macro AXIS_MUX_PKT_CNT_EN, defined: pkt_cnt increments by 1 on each accepted input beat with tlast = 1 and wraps from 0xFFFF to 0x0000.
- Macro undefined: no counter logic; pkt_cnt is driven constant 0.

## Test plan
- Reset with all 12 tvalid high, then release rst → cycle after release: bus_sel = 128, only axis_in_0_tready = 1; first output beat equals channel 0's data.
- Channels 3 and 7 each offer a 2-beat packet (0xA0, 0xA1 / 0xB0, 0xB1), tready constantly 1 → output sequence A0, A1(tlast), B0, B1(tlast); bus_sel shows 131, then 0 for one cycle, then 135.
- Channel 5 sends a 4-beat packet while axis_out_tready is held low for 5 cycles after beat 2 → output shows beat 2 held stable, axis_in_5_tready = 0 throughout the stall, all 4 beats delivered in order.
- All 12 channels continuously offer single-beat packets → grant order 0, 1, …, 11, 0; each packet takes 2 cycles.
- Assert rst mid-packet on channel 9 → all outputs return to 0 immediately; after release, channel 0 wins if valid.
- With AXIS_MUX_PKT_CNT_EN: preload to 0xFFFE via 65534 packets (or force), send 2 packets → pkt_cnt reads 0x0000. Without the macro: pkt_cnt stays 0.
